// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command controller: FSM state
// encoding, configuration register addresses and the default frame marker.
package uart_cmd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_GET_ADDR = 2'd1,
      ST_GET_DATA = 2'd2,
      ST_GET_CSUM = 2'd3
   } state_t;

   localparam logic [1:0] ADDR_GAIN   = 2'd0;
   localparam logic [1:0] ADDR_MODE   = 2'd1;
   localparam logic [1:0] ADDR_THRESH = 2'd2;
   localparam logic [1:0] ADDR_DECAY  = 2'd3;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   // XOR checksum over the three leading bytes of a frame.
   function automatic logic [7:0] frame_csum(input logic [7:0] sync_b,
                                             input logic [7:0] addr_b,
                                             input logic [7:0] data_b);
      return sync_b ^ addr_b ^ data_b;
   endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte-receive inputs and configuration/status outputs of the command
// controller; the controller uses the slave modport, the UART side the master.
interface uart_cmd_ctrl_if;
   logic [7:0] rx_data;
   logic       rx_load;
   logic       rx_error;
   logic [7:0] cfg_gain;
   logic [7:0] cfg_mode;
   logic [7:0] cfg_thresh;
   logic [7:0] cfg_decay;
   logic       cmd_ok;
   logic       cmd_err;
   logic       busy;
   logic [7:0] err_cnt;

   modport master (
      output rx_data, rx_load, rx_error,
      input  cfg_gain, cfg_mode, cfg_thresh, cfg_decay,
      input  cmd_ok, cmd_err, busy, err_cnt
   );

   modport slave (
      input  rx_data, rx_load, rx_error,
      output cfg_gain, cfg_mode, cfg_thresh, cfg_decay,
      output cmd_ok, cmd_err, busy, err_cnt
   );
endinterface

// File: rtl/uart_cmd_timer.sv
// Inter-byte gap counter: cleared by i_clear, counts while i_enable, and flags
// o_expired in the cycle that completes TIMEOUT_CYC cycles without a clear.
module uart_cmd_timer #(
   parameter logic [15:0] TIMEOUT_CYC = 16'd2560
) (
   input  logic clkx16,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   logic [15:0] r_cnt;

   always_ff @(posedge clkx16 or posedge reset) begin
      if (reset) begin
         r_cnt <= 16'd0;
      end else if (i_clear) begin
         r_cnt <= 16'd0;
      end else if (i_enable) begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   // r_cnt holds the idle cycles already elapsed, so this cycle is the last one allowed.
   assign o_expired = i_enable && !i_clear && (r_cnt == TIMEOUT_CYC - 16'd1);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command frame decoder writing four configuration registers.
// Define UART_CSUM_EN for 4-byte frames with an XOR checksum; default is 3-byte frames.
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
   parameter logic [15:0] TIMEOUT_CYC = 16'd2560,
   parameter logic [7:0]  GAIN_RST    = 8'h10
) (
   input logic            clkx16,
   input logic            reset,
   uart_cmd_ctrl_if.slave bus
);

   state_t     r_state;
   logic [1:0] r_addr;
   logic [7:0] r_data;
   logic [7:0] r_cfg_gain;
   logic [7:0] r_cfg_mode;
   logic [7:0] r_cfg_thresh;
   logic [7:0] r_cfg_decay;
   logic       r_cmd_ok;
   logic       r_cmd_err;
   logic [7:0] r_err_cnt;

   logic       w_expired;
   logic       w_commit;
   logic       w_reject;
   logic [7:0] w_wdata;

   uart_cmd_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clkx16    (clkx16),
      .reset     (reset),
      .i_clear   ((r_state == ST_IDLE) || bus.rx_load),
      .i_enable  (r_state != ST_IDLE),
      .o_expired (w_expired)
   );

   // Frame outcome for this cycle; rx_error beats rx_load beats timeout.
   always_comb begin
      w_commit = 1'b0;
      w_reject = 1'b0;
      w_wdata  = r_data;
      if (r_state != ST_IDLE) begin
         if (bus.rx_error) begin
            w_reject = 1'b1;
         end else if (bus.rx_load) begin
            case (r_state)
               ST_GET_ADDR: w_reject = |bus.rx_data[7:2];
`ifndef UART_CSUM_EN
               ST_GET_DATA: begin
                  w_commit = 1'b1;
                  w_wdata  = bus.rx_data;
               end
`else
               ST_GET_CSUM: begin
                  if (bus.rx_data == frame_csum(SYNC_BYTE, {6'b0, r_addr}, r_data)) begin
                     w_commit = 1'b1;
                  end else begin
                     w_reject = 1'b1;
                  end
               end
`endif
               default: ;
            endcase
         end else if (w_expired) begin
            w_reject = 1'b1;
         end
      end
   end

   // Frame payload holding registers; only meaningful while a frame is open.
   always_ff @(posedge clkx16) begin
      if (bus.rx_load && (r_state == ST_GET_ADDR)) begin
         r_addr <= bus.rx_data[1:0];
      end
      if (bus.rx_load && (r_state == ST_GET_DATA)) begin
         r_data <= bus.rx_data;
      end
   end

   always_ff @(posedge clkx16 or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_cfg_gain   <= GAIN_RST;
         r_cfg_mode   <= 8'h00;
         r_cfg_thresh <= 8'h00;
         r_cfg_decay  <= 8'h00;
         r_cmd_ok     <= 1'b0;
         r_cmd_err    <= 1'b0;
         r_err_cnt    <= 8'h00;
      end else begin
         r_cmd_ok  <= w_commit;
         r_cmd_err <= w_reject;
         if (w_reject) begin
            r_state <= ST_IDLE;
            if (r_err_cnt != 8'hFF) begin
               r_err_cnt <= r_err_cnt + 8'd1;
            end
         end else if (w_commit) begin
            r_state <= ST_IDLE;
            case (r_addr)
               ADDR_GAIN:   r_cfg_gain   <= w_wdata;
               ADDR_MODE:   r_cfg_mode   <= w_wdata;
               ADDR_THRESH: r_cfg_thresh <= w_wdata;
               default:     r_cfg_decay  <= w_wdata;
            endcase
         end else if (bus.rx_load) begin
            case (r_state)
               ST_IDLE: begin
                  if (bus.rx_data == SYNC_BYTE) begin
                     r_state <= ST_GET_ADDR;
                  end
               end
               ST_GET_ADDR: r_state <= ST_GET_DATA;
`ifdef UART_CSUM_EN
               ST_GET_DATA: r_state <= ST_GET_CSUM;
`endif
               default: ;
            endcase
         end
      end
   end

   assign bus.cfg_gain   = r_cfg_gain;
   assign bus.cfg_mode   = r_cfg_mode;
   assign bus.cfg_thresh = r_cfg_thresh;
   assign bus.cfg_decay  = r_cfg_decay;
   assign bus.cmd_ok     = r_cmd_ok;
   assign bus.cmd_err    = r_cmd_err;
   assign bus.busy       = (r_state != ST_IDLE);
   assign bus.err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Randomized bench for uart_cmd_ctrl against a frame-level reference model;
// follows the DUT build (3-byte frames, or 4-byte when UART_CSUM_EN is defined).
module tb_uart_cmd_ctrl;

   localparam logic [7:0] SYNC = 8'hA5;
   localparam int         TMO  = 2560;
`ifdef UART_CSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic clkx16 = 1'b0;
   logic reset;
   always #5 clkx16 = ~clkx16;

   uart_cmd_ctrl_if bus ();

   uart_cmd_ctrl #(
      .SYNC_BYTE   (SYNC),
      .TIMEOUT_CYC (16'd2560),
      .GAIN_RST    (8'h10)
   ) dut (
      .clkx16 (clkx16),
      .reset  (reset),
      .bus    (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: position within the frame plus collected bytes.
   int         m_pos;
   logic [7:0] m_addr, m_data;
   logic [7:0] m_cfg [4];
   int         m_errcnt, m_ok_tot, m_err_tot;
   int         seen_ok, seen_err;
   bit         both_hi = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_pos = 0;
      m_cfg[0] = 8'h10; m_cfg[1] = 8'h00; m_cfg[2] = 8'h00; m_cfg[3] = 8'h00;
      m_errcnt = 0; m_ok_tot = 0; m_err_tot = 0;
      seen_ok = 0; seen_err = 0;
   endfunction

   function automatic void model_reject();
      m_pos = 0;
      m_err_tot++;
      if (m_errcnt < 255) m_errcnt++;
   endfunction

   // Returns 0 = nothing, 1 = commit, 2 = reject for one receive event.
   function automatic int model_event(input logic [7:0] b, input bit err, input bit load);
      int res = 0;
      if (m_pos == 0) begin
         if (load && b == SYNC) m_pos = 1;
      end else if (err) begin
         res = 2;
      end else if (load) begin
         case (m_pos)
            1: begin
               if (b[7:2] != 6'd0) res = 2;
               else begin m_addr = b; m_pos = 2; end
            end
            2: begin
               m_data = b;
               if (CSUM) m_pos = 3; else res = 1;
            end
            default: res = (b == (SYNC ^ m_addr ^ m_data)) ? 1 : 2;
         endcase
      end
      if (res == 1) begin
         m_cfg[m_addr[1:0]] = m_data;
         m_pos = 0;
         m_ok_tot++;
      end else if (res == 2) begin
         model_reject();
      end
      return res;
   endfunction

   task automatic tick();
      @(posedge clkx16);
      #1;
      if (bus.cmd_ok)  seen_ok++;
      if (bus.cmd_err) seen_err++;
      if (bus.cmd_ok && bus.cmd_err) both_hi = 1'b1;
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".busy"},   bus.busy,       m_pos != 0);
      chk({tag, ".errcnt"}, bus.err_cnt,    m_errcnt);
      chk({tag, ".gain"},   bus.cfg_gain,   m_cfg[0]);
      chk({tag, ".mode"},   bus.cfg_mode,   m_cfg[1]);
      chk({tag, ".thresh"}, bus.cfg_thresh, m_cfg[2]);
      chk({tag, ".decay"},  bus.cfg_decay,  m_cfg[3]);
      chk({tag, ".n_ok"},   seen_ok,        m_ok_tot);
      chk({tag, ".n_err"},  seen_err,       m_err_tot);
   endtask

   // gap idle cycles (random rx_data, no load), then one event cycle.
   task automatic send(input string tag, input int gap, input logic [7:0] b,
                       input bit err = 1'b0, input bit load = 1'b1);
      int res;
      bus.rx_load  = 1'b0;
      bus.rx_error = 1'b0;
      if (m_pos != 0 && gap >= TMO) model_reject();
      for (int i = 0; i < gap; i++) begin
         bus.rx_data = 8'($urandom);
         tick();
      end
      res = model_event(b, err, load);
      bus.rx_data  = b;
      bus.rx_load  = load;
      bus.rx_error = err;
      tick();
      bus.rx_load  = 1'b0;
      bus.rx_error = 1'b0;
      chk({tag, ".ok"},  bus.cmd_ok,  res == 1);
      chk({tag, ".err"}, bus.cmd_err, res == 2);
      check_state(tag);
   endtask

   task automatic send_frame(input string tag, input int gap, input logic [7:0] a,
                             input logic [7:0] d, input bit good);
      send(tag, gap, SYNC);
      send(tag, gap, a);
      send(tag, gap, d);
      if (CSUM) send(tag, gap, (SYNC ^ a ^ d) ^ (good ? 8'h00 : 8'h01));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      #1;
      chk("rst.cmd_ok",  bus.cmd_ok,  1'b0);
      chk("rst.cmd_err", bus.cmd_err, 1'b0);
      check_state("rst");
      repeat (3) tick();
      reset = 1'b0;
      seen_ok = 0;
      seen_err = 0;
   endtask

   initial begin
      int r;
      logic [7:0] a, d;
      bus.rx_data  = 8'h00;
      bus.rx_load  = 1'b0;
      bus.rx_error = 1'b0;
      reset        = 1'b1;
      tick();
      do_reset();
      tick();
      check_state("idle");

      send_frame("thresh", 160, 8'h02, 8'h3C, 1'b1);
      chk("thresh.val", bus.cfg_thresh, 8'h3C);

      send("badcs", 5, SYNC);
      send("badcs", 5, 8'h01);
      send("badcs", 5, 8'h07);
      if (CSUM) send("badcs", 5, 8'h00);

      send("badaddr", 3, SYNC);
      send("badaddr", 3, 8'h84);

      send("tmo", 2, SYNC);
      send("tmo", TMO, 8'h00);
      send_frame("aftertmo", 4, 8'h00, 8'h5A, 1'b1);

      send_frame("edge", TMO - 1, 8'h01, 8'h33, 1'b1);

      send("rxerr", 1, SYNC);
      send("rxerr", 1, 8'h00);
      send("rxerr", 1, 8'h77, 1'b1, 1'b1);
      send("garbage", 1, 8'h11);
      send("garbage", 1, 8'h22);

      send("erronly", 1, SYNC);
      send("erronly", 2, 8'h00, 1'b1, 1'b0);
      send("idleerr", 2, SYNC, 1'b1, 1'b1);
      send("idleerr", 1, 8'h03);
      send("idleerr", 1, SYNC);
      if (CSUM) send("idleerr", 1, SYNC ^ 8'h03 ^ SYNC);

      send_frame("syncdata", 1, 8'h03, SYNC, 1'b1);
      send_frame("syncaddr", 1, SYNC, 8'h42, 1'b1);

      for (int k = 0; k < 250; k++) begin
         r = $urandom_range(0, 99);
         a = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
         d = 8'($urandom);
         if (r < 60)      send_frame("rnd.frame", $urandom_range(0, 6), a, d, 1'b1);
         else if (r < 75) send_frame("rnd.bad", $urandom_range(0, 6), a | 8'h04, d, $urandom_range(0, 1) == 1);
         else if (r < 85) send("rnd.byte", $urandom_range(0, 8), ($urandom_range(0, 1) == 1) ? SYNC : d);
         else if (r < 95) send("rnd.err", $urandom_range(0, 4), d, 1'b1, $urandom_range(0, 1) == 1);
         else             send("rnd.long", TMO - 1 + $urandom_range(0, 1), d);
      end

      for (int k = 0; k < 260; k++) begin
         send("sat", 0, SYNC);
         send("sat", 0, 8'hFC);
      end
      chk("sat.errcnt", bus.err_cnt, 8'hFF);

      send("midrst", 1, SYNC);
      send("midrst", 1, 8'h00);
      do_reset();
      chk("midrst.gain", bus.cfg_gain, 8'h10);
      tick();
      chk("midrst.noerr", seen_err, 0);
      send_frame("postrst", 2, 8'h03, 8'hC3, 1'b1);

      chk("exclusive", both_hi, 1'b0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
